// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter sharing one data memory between core and debug requesters
module data_mem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    output logic          c_done,
    output logic [31:0]   c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_done,
    output logic [31:0]   d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata,
    output logic          core_stall
);

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       last;       // 0 = core, 1 = debug; doubles as the owner of the current transaction
    logic       we_q;
    logic [2:0] cnt;
    logic       grant;
    logic       grant_sel;
    logic       last_beat;

    assign last_beat = (state == WAIT) && (cnt == LAT_LAST);

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_sel = last;
        case (state)
            IDLE: begin
                if (c_req || d_req) begin
                    grant     = 1'b1;
                    grant_sel = (c_req && d_req) ? ~last : d_req;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: state_nxt = we_q ? DONE : WAIT;
            WAIT: begin
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // The requester just served is ignored here, so the other side gets a turn.
                if (last ? c_req : d_req) begin
                    grant     = 1'b1;
                    grant_sel = ~last;
                    state_nxt = ACCESS;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            we_q    <= 1'b0;
            cnt     <= 3'd0;
            m_addr  <= '0;
            m_wdata <= 32'd0;
            c_rdata <= 32'd0;
            d_rdata <= 32'd0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                last    <= grant_sel;
                we_q    <= grant_sel ? d_we    : c_we;
                m_addr  <= grant_sel ? d_addr  : c_addr;
                m_wdata <= grant_sel ? d_wdata : c_wdata;
            end
            if (state == ACCESS) begin
                cnt <= 3'd0;
            end else if (state == WAIT) begin
                cnt <= cnt + 3'd1;
            end
            if (last_beat) begin
                if (last) begin
                    d_rdata <= m_rdata;
                end else begin
                    c_rdata <= m_rdata;
                end
            end
        end
    end

    assign m_en       = (state == ACCESS);
    assign m_we       = m_en && we_q;
    assign c_done     = (state == DONE) && !last;
    assign d_done     = (state == DONE) && last;
    assign core_stall = c_req && !c_done;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter at MEM_LAT 1 and 4
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;

    logic        c_done1, d_done1, m_en1, m_we1, core_stall1;
    logic [31:0] c_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
    logic        c_done4, d_done4, m_en4, m_we4, core_stall4;
    logic [31:0] c_rdata4, d_rdata4, m_addr4, m_wdata4, m_rdata4;

    logic [31:0] mem [64];
    logic        pv1;
    logic [5:0]  pa1;
    logic [3:0]  pv4;
    logic [5:0]  pa4 [4];

    int pass_cnt  = 0;
    int total_cnt = 0;

    data_mem_arbiter #(.MEM_LAT(1), .AW(32)) dut1 (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_done(c_done1), .c_rdata(c_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done1), .d_rdata(d_rdata1),
        .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_rdata(m_rdata1), .core_stall(core_stall1)
    );

    data_mem_arbiter #(.MEM_LAT(4), .AW(32)) dut4 (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_done(c_done4), .c_rdata(c_rdata4),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done4), .d_rdata(d_rdata4),
        .m_en(m_en4), .m_we(m_we4), .m_addr(m_addr4), .m_wdata(m_wdata4),
        .m_rdata(m_rdata4), .core_stall(core_stall4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory read data exists only in cycle ACCESS+MEM_LAT; any other cycle shows a poison word.
    always @(posedge clk) begin
        pv1    <= m_en1 && !m_we1;
        pa1    <= m_addr1[7:2];
        pv4    <= {pv4[2:0], m_en4 && !m_we4};
        pa4[0] <= m_addr4[7:2];
        for (int i = 1; i < 4; i++) pa4[i] <= pa4[i-1];
    end
    assign m_rdata1 = pv1    ? mem[pa1]    : 32'h0BAD0BAD;
    assign m_rdata4 = pv4[3] ? mem[pa4[3]] : 32'h0BAD0BAD;

    task automatic do_reset;
        rst   = 1'b0;
        c_req = 1'b0;
        d_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({m_en1, m_we1, c_done1, d_done1, core_stall1} !== 5'b0)
            $display("FAIL reset_ctrl1 got %b exp 00000", {m_en1, m_we1, c_done1, d_done1, core_stall1});
        else pass_cnt++;
        total_cnt++;
        if ({c_rdata1, d_rdata1, m_addr1, m_wdata1} !== 128'd0)
            $display("FAIL reset_data1 got %h exp 0", {c_rdata1, d_rdata1, m_addr1, m_wdata1});
        else pass_cnt++;
        total_cnt++;
        if ({m_en4, m_we4, c_done4, d_done4, core_stall4} !== 5'b0)
            $display("FAIL reset_ctrl4 got %b exp 00000", {m_en4, m_we4, c_done4, d_done4, core_stall4});
        else pass_cnt++;
        total_cnt++;
        if ({c_rdata4, d_rdata4, m_addr4, m_wdata4} !== 128'd0)
            $display("FAIL reset_data4 got %h exp 0", {c_rdata4, d_rdata4, m_addr4, m_wdata4});
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_read;
        logic [4:0] e_en;
        logic [4:0] e_done;
        logic [4:0] e_stall;
        e_en    = 5'b00010;
        e_done  = 5'b01000;
        e_stall = 5'b00111;
        mem[4]  = 32'hDEADBEEF;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_wdata = 32'd0;
            end
            if (k == 4) c_req = 1'b0;
            @(negedge clk);
            total_cnt++;
            if (m_en1 !== e_en[k]) $display("FAIL read_m_en k=%0d got %b exp %b", k, m_en1, e_en[k]);
            else pass_cnt++;
            total_cnt++;
            if (c_done1 !== e_done[k]) $display("FAIL read_c_done k=%0d got %b exp %b", k, c_done1, e_done[k]);
            else pass_cnt++;
            total_cnt++;
            if (core_stall1 !== e_stall[k]) $display("FAIL read_stall k=%0d got %b exp %b", k, core_stall1, e_stall[k]);
            else pass_cnt++;
            if (k == 1) begin
                total_cnt++;
                if ({m_we1, m_addr1} !== {1'b0, 32'h10}) $display("FAIL read_m_addr got %b/%h exp 0/00000010", m_we1, m_addr1);
                else pass_cnt++;
            end
            if (k >= 3) begin
                total_cnt++;
                if (c_rdata1 !== 32'hDEADBEEF) $display("FAIL read_c_rdata k=%0d got %h exp deadbeef", k, c_rdata1);
                else pass_cnt++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write;
        logic [3:0] e_en;
        logic [3:0] e_done;
        e_en   = 4'b0010;
        e_done = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                c_req = 1'b1; c_we = 1'b1; c_addr = 32'h8; c_wdata = 32'h4;
            end
            if (k == 3) c_req = 1'b0;
            @(negedge clk);
            total_cnt++;
            if ({m_en1, m_we1} !== {e_en[k], e_en[k]}) $display("FAIL write_m_en_we k=%0d got %b%b exp %b%b", k, m_en1, m_we1, e_en[k], e_en[k]);
            else pass_cnt++;
            total_cnt++;
            if (c_done1 !== e_done[k]) $display("FAIL write_c_done k=%0d got %b exp %b", k, c_done1, e_done[k]);
            else pass_cnt++;
            if (k == 1 || k == 2) begin
                total_cnt++;
                if ({m_addr1, m_wdata1} !== {32'h8, 32'h4}) $display("FAIL write_m_addr_wdata k=%0d got %h/%h exp 00000008/00000004", k, m_addr1, m_wdata1);
                else pass_cnt++;
            end
            if (k == 3) begin
                total_cnt++;
                if (c_rdata1 !== 32'hDEADBEEF) $display("FAIL write_c_rdata_hold got %h exp deadbeef", c_rdata1);
                else pass_cnt++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_both;
        logic [5:0] e_c;
        logic [5:0] e_d;
        logic [5:0] e_en;
        e_c  = 6'b000100;
        e_d  = 6'b010000;
        e_en = 6'b001010;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                c_req = 1'b1; c_we = 1'b1; c_addr = 32'h20; c_wdata = 32'h11;
                d_req = 1'b1; d_we = 1'b1; d_addr = 32'h24; d_wdata = 32'h22;
            end
            if (k == 3) c_req = 1'b0;
            if (k == 5) d_req = 1'b0;
            @(negedge clk);
            total_cnt++;
            if ({c_done1, d_done1} !== {e_c[k], e_d[k]}) $display("FAIL both_done k=%0d got %b%b exp %b%b", k, c_done1, d_done1, e_c[k], e_d[k]);
            else pass_cnt++;
            total_cnt++;
            if (m_en1 !== e_en[k]) $display("FAIL both_m_en k=%0d got %b exp %b", k, m_en1, e_en[k]);
            else pass_cnt++;
            if (k == 1) begin
                total_cnt++;
                if ({m_addr1, m_wdata1} !== {32'h20, 32'h11}) $display("FAIL both_core_access got %h/%h exp 00000020/00000011", m_addr1, m_wdata1);
                else pass_cnt++;
            end
            if (k == 3) begin
                total_cnt++;
                if ({m_addr1, m_wdata1} !== {32'h24, 32'h22}) $display("FAIL both_dbg_access got %h/%h exp 00000024/00000022", m_addr1, m_wdata1);
                else pass_cnt++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alternate;
        logic exp_c;
        logic exp_d;
        do_reset();
        for (int k = 0; k < 17; k++) begin
            if (k == 0) begin
                c_req = 1'b1; c_we = 1'b1; c_addr = 32'h28; c_wdata = 32'h33;
                d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2C; d_wdata = 32'h44;
            end
            exp_c = (k % 4 == 2);
            exp_d = (k % 4 == 0) && (k >= 4);
            @(negedge clk);
            total_cnt++;
            if ({c_done1, d_done1} !== {exp_c, exp_d}) $display("FAIL alternate_done k=%0d got %b%b exp %b%b", k, c_done1, d_done1, exp_c, exp_d);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        c_req = 1'b0;
        d_req = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] exp_rd;
        do_reset();
        mem[12] = 32'hCAFEF00D;
        mem[13] = 32'h12345678;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30; d_wdata = 32'd0;
            end
            if (k == 7) d_req = 1'b0;
            @(negedge clk);
            total_cnt++;
            if ({m_en4, d_done4} !== {k == 1, k == 6}) $display("FAIL lat4_read k=%0d got en=%b done=%b exp en=%b done=%b", k, m_en4, d_done4, k == 1, k == 6);
            else pass_cnt++;
            if (k == 6) begin
                total_cnt++;
                if (d_rdata4 !== 32'hCAFEF00D) $display("FAIL lat4_d_rdata got %h exp cafef00d", d_rdata4);
                else pass_cnt++;
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 12; k++) begin
            if (k == 0) begin
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h34;
            end
            if (k == 3) rst = 1'b0;
            if (k == 5) rst = 1'b1;
            @(negedge clk);
            total_cnt++;
            if ({m_en4, d_done4} !== {k == 1 || k == 6, k == 11}) $display("FAIL abort_seq k=%0d got en=%b done=%b exp en=%b done=%b", k, m_en4, d_done4, k == 1 || k == 6, k == 11);
            else pass_cnt++;
            if (k == 3 || k == 11) begin
                exp_rd = (k == 3) ? 32'd0 : 32'h12345678;
                total_cnt++;
                if (d_rdata4 !== exp_rd) $display("FAIL abort_d_rdata k=%0d got %h exp %h", k, d_rdata4, exp_rd);
                else pass_cnt++;
            end
            @(posedge clk); #1;
        end
        d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst     = 1'b0;
        c_req   = 1'b0;
        c_we    = 1'b0;
        c_addr  = 32'd0;
        c_wdata = 32'd0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'd0;
        d_wdata = 32'd0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_read();
        test_write();
        test_both();
        test_alternate();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, SHALL be the data-memory read latency in cycles, legal range 1..8.
REQ-002 Parameter AW, default 32, SHALL be the address width; data width SHALL be fixed at 32.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 c_req, c_we  input  1 each  SHALL be the core load/store request and write-enable.
REQ-006 c_addr  input  AW  SHALL be the core address; c_wdata  input  32  SHALL be the core store data.
REQ-007 c_done  output  1  SHALL be the core completion pulse; c_rdata  output  32  SHALL be the core load data.
REQ-008 d_req, d_we, d_addr, d_wdata, d_done, d_rdata SHALL mirror the core ports for the debug/loader requester.
REQ-009 m_en, m_we  output  1 each  SHALL be the memory access strobe and write-enable.
REQ-010 m_addr  output  AW  and  m_wdata  output  32  SHALL be the memory address and write data; m_rdata  input  32  SHALL be the memory read data.
REQ-011 core_stall  output  1  SHALL freeze the processor PC and register writeback.

Function
REQ-012 FSM states SHALL be IDLE, ACCESS, WAIT and DONE.
REQ-013 Requester rule: once asserted, x_req, x_we, x_addr and x_wdata SHALL be held stable through the x_done cycle; the arbiter SHALL latch them on grant regardless.
REQ-014 IDLE: with any request, SHALL select a winner, latch its fields and go to ACCESS next cycle; with no request, SHALL stay in IDLE.
REQ-015 Simultaneous requests SHALL be resolved round-robin: the requester not served last wins; the pointer SHALL update on every grant.
REQ-016 ACCESS (exactly 1 cycle): m_en=1; m_we, m_addr and m_wdata SHALL be driven from the latched fields.
REQ-017 ACCESS next state: write SHALL go to DONE; read SHALL go to WAIT.
REQ-018 Read timing: with ACCESS in cycle t, m_rdata SHALL be valid in cycle t+MEM_LAT.
REQ-019 WAIT: a 3-bit counter SHALL hold the FSM until cycle t+MEM_LAT, then capture m_rdata and go to DONE.
REQ-020 DONE (1 cycle): the served requester's x_done=1; for a read, x_rdata SHALL equal the captured word.
REQ-021 x_rdata SHALL hold its last value until the next read for that requester completes.
REQ-022 End-to-end latency with request seen in IDLE at cycle t0: write done at t0+2; read done at t0+2+MEM_LAT.
REQ-023 In DONE, the served requester's req SHALL be ignored.
REQ-024 DONE exit: if the other requester is requesting, SHALL grant it and go directly to ACCESS; otherwise SHALL go to IDLE.
REQ-025 Outside ACCESS, m_en and m_we SHALL be 0; m_addr and m_wdata SHALL hold their last values.
REQ-026 core_stall SHALL equal c_req AND NOT c_done (combinational).
REQ-027 Only one x_done SHALL be asserted in any cycle; x_done SHALL never assert without a prior grant.

Reset
REQ-028 On rst low, asynchronously: state=IDLE; m_en, m_we, c_done and d_done = 0; c_rdata, d_rdata, m_addr and m_wdata = 0; wait counter = 0; round-robin pointer SHALL favour the core.
REQ-029 Reset asserted mid-access SHALL abandon the transaction with no x_done; after release, the FSM SHALL restart from IDLE.
REQ-030 The first rising edge after rst goes high SHALL be treated as an IDLE cycle.

Verification
REQ-031 MEM_LAT=1, core read of 0x10 with memory returning 0xDEADBEEF, request at cycle 0 -> m_en=1 in cycle 1, c_done=1 and c_rdata=0xDEADBEEF in cycle 3, core_stall=1 in cycles 0..2.
REQ-032 Core write of 0x0000_0004 to address 0x8, request at cycle 0 -> m_en=m_we=1 with m_addr=0x8 in cycle 1, c_done in cycle 2, no WAIT.
REQ-033 Both requesters request at cycle 0 after reset -> core served first (c_done in cycle 2 for a write); debug enters ACCESS in cycle 3 directly from DONE.
REQ-034 Debug continuously requesting and core requesting at the same time -> grants strictly alternate; no requester is served twice in a row while the other waits.
REQ-035 MEM_LAT=4, debug read, request at cycle 0 -> d_done in cycle 6; asserting rst in cycle 3 -> no d_done is produced, m_en=0 immediately, and state is IDLE after release.
